// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared control-bit indices, FSM states and word sizes for the MIPS pipeline
package mips_pipe_pkg;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFS_W = 2;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed data memory, synchronous write, asynchronous read
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // Deliberately never reset: contents survive Rst.
  logic [31:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with multi-cycle data memory, MEM/WB register and writeback port
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  WB_MEM,
  input  logic [1:0]  MEM_MEM,
  input  logic [4:0]  WN_MEM,
  input  logic [31:0] RD2_MEM,
  input  logic [31:0] DataOut_MEM,
  output logic        Stall,
  output logic        AlignErr,
  output logic [1:0]  WB_WB,
  output logic [31:0] RD_WB,
  output logic [31:0] ALU_WB,
  output logic [4:0]  WN_WB,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              mem_rd, mem_wr, memop, misaligned;
  logic              done, capture, we;
  logic [31:0]       rdata, load_data;

  assign mem_rd     = MEM_MEM[MEM_MEMREAD];
  assign mem_wr     = MEM_MEM[MEM_MEMWRITE];
  assign memop      = mem_rd | mem_wr;
  assign misaligned = memop & (DataOut_MEM[BYTE_OFS_W-1:0] != '0);

  // With MEM_LAT==1 the access finishes in IDLE; otherwise only on the last BUSY cycle.
  assign done    = (MEM_LAT == 1) ? 1'b1
                 : ((state == BUSY) && (cnt == CNT_W'(MEM_LAT - 1)));
  assign capture = (state == BUSY) ? done : (~memop | done);
  assign Stall   = (state == BUSY) ? ~done : (memop & ~done);

  // Rst gating discards a store whose completion edge coincides with reset.
  assign we        = mem_wr & ~misaligned & done & ~Rst;
  assign load_data = (mem_rd & ~mem_wr & ~misaligned) ? rdata : 32'd0;

  dmem_array #(.ADDR_W(ADDR_W)) u_mem (
    .Clk   (Clk),
    .we    (we),
    .addr  (DataOut_MEM[ADDR_W+1:2]),
    .wdata (RD2_MEM),
    .rdata (rdata)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      AlignErr <= 1'b0;
      WB_WB    <= 2'b00;
      RD_WB    <= 32'd0;
      ALU_WB   <= 32'd0;
      WN_WB    <= 5'd0;
    end else begin
      if (misaligned) AlignErr <= 1'b1;

      if (capture) begin
        WB_WB  <= {WB_MEM[WB_REGWRITE] & ~misaligned, WB_MEM[WB_MEMTOREG]};
        RD_WB  <= load_data;
        ALU_WB <= DataOut_MEM;
        WN_WB  <= WN_MEM;
      end else begin
        WB_WB  <= 2'b00;
        RD_WB  <= 32'd0;
        ALU_WB <= 32'd0;
        WN_WB  <= 5'd0;
      end

      case (state)
        IDLE: begin
          if (memop && (MEM_LAT > 1)) begin
            state <= BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign RegWrite  = WB_WB[WB_REGWRITE];
  assign WriteReg  = WN_WB;
  assign WriteData = WB_WB[WB_MEMTOREG] ? RD_WB : ALU_WB;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed checks of mem_wb_stage at MEM_LAT=2 and MEM_LAT=3
module tb_mem_wb_stage;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int assertions = 0;
  int failures   = 0;

  logic        a_rst, a_stall, a_aerr, a_regw;
  logic [1:0]  a_wb, a_mem, a_wbwb;
  logic [4:0]  a_wn, a_wnwb, a_wreg;
  logic [31:0] a_rd2, a_addr, a_rdwb, a_aluwb, a_wdata;

  logic        b_rst, b_stall, b_aerr, b_regw;
  logic [1:0]  b_wb, b_mem, b_wbwb;
  logic [4:0]  b_wn, b_wnwb, b_wreg;
  logic [31:0] b_rd2, b_addr, b_rdwb, b_aluwb, b_wdata;

  mem_wb_stage #(.MEM_LAT(2), .ADDR_W(8)) u_dut2 (
    .Clk(Clk), .Rst(a_rst), .WB_MEM(a_wb), .MEM_MEM(a_mem), .WN_MEM(a_wn),
    .RD2_MEM(a_rd2), .DataOut_MEM(a_addr), .Stall(a_stall), .AlignErr(a_aerr),
    .WB_WB(a_wbwb), .RD_WB(a_rdwb), .ALU_WB(a_aluwb), .WN_WB(a_wnwb),
    .RegWrite(a_regw), .WriteReg(a_wreg), .WriteData(a_wdata)
  );

  mem_wb_stage #(.MEM_LAT(3), .ADDR_W(8)) u_dut3 (
    .Clk(Clk), .Rst(b_rst), .WB_MEM(b_wb), .MEM_MEM(b_mem), .WN_MEM(b_wn),
    .RD2_MEM(b_rd2), .DataOut_MEM(b_addr), .Stall(b_stall), .AlignErr(b_aerr),
    .WB_WB(b_wbwb), .RD_WB(b_rdwb), .ALU_WB(b_aluwb), .WN_WB(b_wnwb),
    .RegWrite(b_regw), .WriteReg(b_wreg), .WriteData(b_wdata)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] wb, input logic [1:0] mem,
                         input logic [31:0] addr, input logic [31:0] rd2, input logic [4:0] wn);
    a_wb = wb; a_mem = mem; a_addr = addr; a_rd2 = rd2; a_wn = wn;
  endtask

  task automatic b_drive(input logic [1:0] wb, input logic [1:0] mem,
                         input logic [31:0] addr, input logic [31:0] rd2, input logic [4:0] wn);
    b_wb = wb; b_mem = mem; b_addr = addr; b_rd2 = rd2; b_wn = wn;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    b_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    assertions++; if (a_wbwb !== 2'b00) begin failures++; $display("FAIL reset_wbwb act=%b exp=00", a_wbwb); end
    assertions++; if (a_aluwb !== 32'd0 || a_rdwb !== 32'd0 || a_wnwb !== 5'd0) begin failures++; $display("FAIL reset_fields act=%h/%h/%h exp=0", a_aluwb, a_rdwb, a_wnwb); end
    assertions++; if (a_aerr !== 1'b0 || b_aerr !== 1'b0) begin failures++; $display("FAIL reset_alignerr act=%b/%b exp=0", a_aerr, b_aerr); end
    assertions++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin failures++; $display("FAIL reset_stall act=%b/%b exp=0", a_stall, b_stall); end
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_alu_op();
    a_drive(2'b10, 2'b00, 32'h1234, 32'd0, 5'd5);
    #1;
    assertions++; if (a_stall !== 1'b0) begin failures++; $display("FAIL alu_stall act=%b exp=0", a_stall); end
    tick();
    assertions++; if (a_regw !== 1'b1 || a_wreg !== 5'd5) begin failures++; $display("FAIL alu_dest act=%b/%0d exp=1/5", a_regw, a_wreg); end
    assertions++; if (a_wdata !== 32'h1234) begin failures++; $display("FAIL alu_wdata act=%h exp=00001234", a_wdata); end
    assertions++; if (a_stall !== 1'b0) begin failures++; $display("FAIL alu_stall_after act=%b exp=0", a_stall); end
    a_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_store();
    a_drive(2'b00, 2'b01, 32'h40, 32'hDEADBEEF, 5'd0);
    #1;
    assertions++; if (a_stall !== 1'b1) begin failures++; $display("FAIL store_stall_first act=%b exp=1", a_stall); end
    tick();
    assertions++; if (a_stall !== 1'b0) begin failures++; $display("FAIL store_stall_done act=%b exp=0", a_stall); end
    assertions++; if (a_wbwb !== 2'b00 || a_aluwb !== 32'd0) begin failures++; $display("FAIL store_bubble act=%b/%h exp=00/0", a_wbwb, a_aluwb); end
    tick();
    assertions++; if (u_dut2.u_mem.mem[16] !== 32'hDEADBEEF) begin failures++; $display("FAIL store_array act=%h exp=deadbeef", u_dut2.u_mem.mem[16]); end
    assertions++; if (a_regw !== 1'b0 || a_aluwb !== 32'h40) begin failures++; $display("FAIL store_capture act=%b/%h exp=0/40", a_regw, a_aluwb); end
  endtask

  task automatic test_load_after_store();
    a_drive(2'b11, 2'b10, 32'h40, 32'd0, 5'd9);
    #1;
    assertions++; if (a_stall !== 1'b1) begin failures++; $display("FAIL load_stall act=%b exp=1", a_stall); end
    tick();
    assertions++; if (a_regw !== 1'b0) begin failures++; $display("FAIL load_bubble act=%b exp=0", a_regw); end
    tick();
    assertions++; if (a_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_wdata act=%h exp=deadbeef", a_wdata); end
    assertions++; if (a_regw !== 1'b1 || a_wreg !== 5'd9) begin failures++; $display("FAIL load_dest act=%b/%0d exp=1/9", a_regw, a_wreg); end
    a_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_misaligned();
    a_drive(2'b11, 2'b10, 32'h42, 32'd0, 5'd3);
    #1;
    assertions++; if (a_stall !== 1'b1) begin failures++; $display("FAIL mis_stall act=%b exp=1", a_stall); end
    tick();
    assertions++; if (a_aerr !== 1'b1) begin failures++; $display("FAIL mis_alignerr act=%b exp=1", a_aerr); end
    tick();
    assertions++; if (a_regw !== 1'b0 || a_wbwb !== 2'b01) begin failures++; $display("FAIL mis_wb act=%b exp=01", a_wbwb); end
    assertions++; if (a_rdwb !== 32'd0 || a_aluwb !== 32'h42) begin failures++; $display("FAIL mis_data act=%h/%h exp=0/42", a_rdwb, a_aluwb); end
    assertions++; if (u_dut2.u_mem.mem[16] !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_array act=%h exp=deadbeef", u_dut2.u_mem.mem[16]); end
    a_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    assertions++; if (a_aerr !== 1'b1) begin failures++; $display("FAIL mis_sticky act=%b exp=1", a_aerr); end
  endtask

  task automatic test_reset_mid_access();
    a_drive(2'b00, 2'b01, 32'h80, 32'h12345678, 5'd0);
    tick(); tick();
    assertions++; if (u_dut2.u_mem.mem[32] !== 32'h12345678) begin failures++; $display("FAIL rst_prestore act=%h exp=12345678", u_dut2.u_mem.mem[32]); end
    a_drive(2'b00, 2'b01, 32'h80, 32'hCAFEF00D, 5'd0);
    tick();
    a_rst = 1'b1;
    a_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    a_rst = 1'b0;
    #1;
    assertions++; if (u_dut2.u_mem.mem[32] !== 32'h12345678) begin failures++; $display("FAIL rst_discard act=%h exp=12345678", u_dut2.u_mem.mem[32]); end
    assertions++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rst_stall act=%b exp=0", a_stall); end
    assertions++; if (a_wbwb !== 2'b00 || a_rdwb !== 32'd0 || a_aluwb !== 32'd0 || a_wnwb !== 5'd0) begin failures++; $display("FAIL rst_outputs act=%b/%h/%h/%h exp=0", a_wbwb, a_rdwb, a_aluwb, a_wnwb); end
    assertions++; if (a_aerr !== 1'b0) begin failures++; $display("FAIL rst_alignerr act=%b exp=0", a_aerr); end
  endtask

  task automatic test_wrap_lat3();
    b_drive(2'b00, 2'b01, 32'h400, 32'h11, 5'd0);
    #1;
    assertions++; if (b_stall !== 1'b1) begin failures++; $display("FAIL wrap_stall0 act=%b exp=1", b_stall); end
    tick();
    assertions++; if (b_stall !== 1'b1) begin failures++; $display("FAIL wrap_stall1 act=%b exp=1", b_stall); end
    tick();
    assertions++; if (b_stall !== 1'b0) begin failures++; $display("FAIL wrap_stall2 act=%b exp=0", b_stall); end
    tick();
    assertions++; if (u_dut3.u_mem.mem[0] !== 32'h11) begin failures++; $display("FAIL wrap_array act=%h exp=11", u_dut3.u_mem.mem[0]); end
    assertions++; if (b_regw !== 1'b0) begin failures++; $display("FAIL wrap_regwrite act=%b exp=0", b_regw); end
  endtask

  task automatic test_back_to_back_lat3();
    b_drive(2'b11, 2'b11, 32'h8, 32'h55, 5'd7);
    tick(); tick(); tick();
    assertions++; if (u_dut3.u_mem.mem[2] !== 32'h55) begin failures++; $display("FAIL rw_array act=%h exp=55", u_dut3.u_mem.mem[2]); end
    assertions++; if (b_wdata !== 32'd0 || b_regw !== 1'b1 || b_wreg !== 5'd7) begin failures++; $display("FAIL rw_wb act=%h/%b/%0d exp=0/1/7", b_wdata, b_regw, b_wreg); end
    b_drive(2'b11, 2'b10, 32'h0, 32'd0, 5'd4);
    tick();
    assertions++; if (b_regw !== 1'b0) begin failures++; $display("FAIL b2b_bubble act=%b exp=0", b_regw); end
    tick(); tick();
    assertions++; if (b_wdata !== 32'h11 || b_wreg !== 5'd4) begin failures++; $display("FAIL b2b_load act=%h/%0d exp=11/4", b_wdata, b_wreg); end
    b_drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_store();
    test_load_after_store();
    test_misaligned();
    test_reset_mid_access();
    test_wrap_lat3();
    test_back_to_back_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
